// File: rtl/norm_pkg.sv
// Shared constants and FSM encoding for the norm_seq vector normaliser.
package norm_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_FBITS = 8;

   localparam logic [DEF_WIDTH-1:0] MAX_POS = {1'b0, {(DEF_WIDTH-1){1'b1}}};
   localparam logic [DEF_WIDTH-1:0] MAX_U   = {DEF_WIDTH{1'b1}};

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_SUMSQ   = 3'd1;
   localparam state_t ST_SQ_REQ  = 3'd2;
   localparam state_t ST_SQ_WAIT = 3'd3;
   localparam state_t ST_DV_REQ  = 3'd4;
   localparam state_t ST_DV_WAIT = 3'd5;
   localparam state_t ST_DONE    = 3'd6;

endpackage

// File: rtl/norm_sumsq.sv
// Combinational saturating sum of squares of four signed fixed-point words.
module norm_sumsq
   import norm_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int FBITS = DEF_FBITS
)(
   input  logic [WIDTH-1:0] h0,
   input  logic [WIDTH-1:0] h1,
   input  logic [WIDTH-1:0] h2,
   input  logic [WIDTH-1:0] h3,
   output logic [WIDTH-1:0] sum_sq
);

   // Square in full precision, drop the extra fraction, clamp if the integer part overflows.
   function automatic logic [WIDTH-1:0] sq_sat(input logic [WIDTH-1:0] v);
      logic signed [2*WIDTH-1:0] s;
      logic        [2*WIDTH-1:0] p;
      logic        [2*WIDTH-1:0] p_s;
      s   = {{WIDTH{v[WIDTH-1]}}, v};
      p   = s * s;
      p_s = p >> FBITS;
      if (|p_s[2*WIDTH-1:WIDTH]) return {WIDTH{1'b1}};
      return p_s[WIDTH-1:0];
   endfunction

   logic [WIDTH+1:0] sum_full;

   always_comb begin
      sum_full = {2'b00, sq_sat(h0)} + {2'b00, sq_sat(h1)}
               + {2'b00, sq_sat(h2)} + {2'b00, sq_sat(h3)};
      sum_sq   = (|sum_full[WIDTH+1:WIDTH]) ? {WIDTH{1'b1}} : sum_full[WIDTH-1:0];
   end

endmodule

// File: rtl/norm_seq.sv
// Vector normaliser: sum of squares, shared sqrt, then four shared divisions.
// Optional engine watchdog (limit TMO_CYC) when NORM_SEQ_TIMEOUT_EN is defined.
module norm_seq
   import norm_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int FBITS   = DEF_FBITS,
   parameter int TMO_CYC = 64
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] h0,
   input  logic [WIDTH-1:0] h1,
   input  logic [WIDTH-1:0] h2,
   input  logic [WIDTH-1:0] h3,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] q0,
   output logic [WIDTH-1:0] q1,
   output logic [WIDTH-1:0] q2,
   output logic [WIDTH-1:0] q3,
   output logic [WIDTH-1:0] norm,
   output logic             err,
   output logic             sq_start,
   output logic [WIDTH-1:0] sq_rad,
   input  logic             sq_valid,
   input  logic [WIDTH-1:0] sq_root,
   output logic             dv_start,
   output logic [WIDTH-1:0] dv_x,
   output logic [WIDTH-1:0] dv_y,
   input  logic             dv_valid,
   input  logic [WIDTH-1:0] dv_q,
   input  logic             dv_dbz,
   input  logic             dv_ovf
);

   localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   if (TMO_CYC < 2) begin : g_tmo_chk
      $error("norm_seq: TMO_CYC must be at least 2");
   end

   state_t           state_q, state_d;
   logic [WIDTH-1:0] h_q [4];
   logic [WIDTH-1:0] h_d [4];
   logic [WIDTH-1:0] q_q [4];
   logic [WIDTH-1:0] q_d [4];
   logic [WIDTH-1:0] sq_rad_q, sq_rad_d;
   logic [WIDTH-1:0] norm_q, norm_d;
   logic [WIDTH-1:0] dv_x_q, dv_x_d;
   logic             err_q, err_d;
   logic [1:0]       idx_q, idx_d;
   logic [WIDTH-1:0] sum_sq;
   logic             tmo_hit;

   // The most negative input has no positive twin, so its magnitude clamps.
   function automatic logic [WIDTH-1:0] abs_sat(input logic [WIDTH-1:0] v);
      if (v == MIN_NEG) return SAT_POS;
      return v[WIDTH-1] ? -v : v;
   endfunction

   norm_sumsq #(.WIDTH(WIDTH), .FBITS(FBITS)) u_sumsq (
      .h0     (h_q[0]),
      .h1     (h_q[1]),
      .h2     (h_q[2]),
      .h3     (h_q[3]),
      .sum_sq (sum_sq)
   );

`ifdef NORM_SEQ_TIMEOUT_EN
   localparam int TMO_W = $clog2(TMO_CYC + 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             in_wait;

   always_comb begin
      in_wait = (state_q == ST_SQ_WAIT && !sq_valid) || (state_q == ST_DV_WAIT && !dv_valid);
      tmo_d   = in_wait ? tmo_q + TMO_W'(1) : '0;
      tmo_hit = in_wait && (tmo_q == TMO_W'(TMO_CYC - 1));
   end

   always_ff @(posedge clk) begin
      if (reset) tmo_q <= '0;
      else       tmo_q <= tmo_d;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      // NOTE: every _d starts from its _q so no branch of the case below can infer a latch.
      state_d  = state_q;
      h_d      = h_q;
      q_d      = q_q;
      sq_rad_d = sq_rad_q;
      norm_d   = norm_q;
      dv_x_d   = dv_x_q;
      err_d    = err_q;
      idx_d    = idx_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               h_d[0]  = h0;
               h_d[1]  = h1;
               h_d[2]  = h2;
               h_d[3]  = h3;
               err_d   = 1'b0;
               state_d = ST_SUMSQ;
            end
         end
         ST_SUMSQ: begin
            sq_rad_d = sum_sq;
            state_d  = ST_SQ_REQ;
         end
         ST_SQ_REQ: state_d = ST_SQ_WAIT;
         ST_SQ_WAIT: begin
            if (sq_valid) begin
               norm_d = sq_root;
               if (sq_root == '0) begin
                  for (int i = 0; i < 4; i++) q_d[i] = '0;
                  err_d   = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  idx_d   = 2'd0;
                  dv_x_d  = abs_sat(h_q[0]);
                  state_d = ST_DV_REQ;
               end
            end else if (tmo_hit) begin
               for (int i = 0; i < 4; i++) q_d[i] = '0;
               err_d   = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DV_REQ: state_d = ST_DV_WAIT;
         ST_DV_WAIT: begin
            if (dv_valid) begin
               if (dv_dbz) begin
                  q_d[idx_q] = '0;
                  err_d      = 1'b1;
               end else if (dv_ovf) begin
                  q_d[idx_q] = h_q[idx_q][WIDTH-1] ? SAT_NEG : SAT_POS;
                  err_d      = 1'b1;
               end else begin
                  q_d[idx_q] = h_q[idx_q][WIDTH-1] ? -dv_q : dv_q;
               end
               if (idx_q == 2'd3) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  dv_x_d  = abs_sat(h_q[idx_q + 2'd1]);
                  state_d = ST_DV_REQ;
               end
            end else if (tmo_hit) begin
               for (int i = 0; i < 4; i++) q_d[i] = '0;
               err_d   = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: if (out_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         // NOTE: h/q are four-entry flop arrays, not RAM, so clearing them in reset is cheap.
         for (int i = 0; i < 4; i++) begin
            h_q[i] <= '0;
            q_q[i] <= '0;
         end
         sq_rad_q <= '0;
         norm_q   <= '0;
         dv_x_q   <= '0;
         err_q    <= 1'b0;
         idx_q    <= 2'd0;
      end else begin
         state_q  <= state_d;
         h_q      <= h_d;
         q_q      <= q_d;
         sq_rad_q <= sq_rad_d;
         norm_q   <= norm_d;
         dv_x_q   <= dv_x_d;
         err_q    <= err_d;
         idx_q    <= idx_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign sq_start  = (state_q == ST_SQ_REQ);
   assign dv_start  = (state_q == ST_DV_REQ);
   assign sq_rad    = sq_rad_q;
   assign dv_x      = dv_x_q;
   assign dv_y      = norm_q;
   assign norm      = norm_q;
   assign err       = err_q;
   assign q0        = q_q[0];
   assign q1        = q_q[1];
   assign q2        = q_q[2];
   assign q3        = q_q[3];

endmodule

// File: tb/tb_norm_seq.sv
// Directed bench for norm_seq with behavioural sqrt (Ts=12) and divider (Td=24) engines.
module tb_norm_seq;
   import norm_pkg::*;

   localparam int W   = 16;
   localparam int FB  = 8;
   localparam int TS  = 12;
   localparam int TD  = 24;
   localparam int TMO = 64;
   localparam int LAT = 3 + TS + 4 * (2 + TD);

   logic         clk = 1'b0;
   logic         reset, in_valid, out_ready;
   logic         in_ready, out_valid, err;
   logic [W-1:0] h0, h1, h2, h3, q0, q1, q2, q3, norm;
   logic         sq_start, sq_valid, dv_start, dv_valid, dv_dbz, dv_ovf;
   logic [W-1:0] sq_rad, sq_root, dv_x, dv_y, dv_q;

   int n_cmp = 0;
   int n_fail = 0;
   logic sq_en = 1'b1;
   int dv_cnt = 0;
   int ovf_at = -1;
   int cyc;

   always #5 clk = ~clk;

   norm_seq #(.WIDTH(W), .FBITS(FB), .TMO_CYC(TMO)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .h0(h0), .h1(h1), .h2(h2), .h3(h3),
      .out_valid(out_valid), .out_ready(out_ready),
      .q0(q0), .q1(q1), .q2(q2), .q3(q3), .norm(norm), .err(err),
      .sq_start(sq_start), .sq_rad(sq_rad), .sq_valid(sq_valid), .sq_root(sq_root),
      .dv_start(dv_start), .dv_x(dv_x), .dv_y(dv_y), .dv_valid(dv_valid),
      .dv_q(dv_q), .dv_dbz(dv_dbz), .dv_ovf(dv_ovf)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] isqrt(input logic [31:0] v);
      logic [31:0] r, t;
      r = 0;
      for (int b = 15; b >= 0; b--) begin
         t = r | (32'd1 << b);
         if (t * t <= v) r = t;
      end
      return r[15:0];
   endfunction

   // Engine samples start mid-cycle, raises valid Ts/Td edges later for one cycle.
   task automatic sq_engine();
      logic [31:0] rad;
      forever begin
         @(negedge clk);
         if (sq_start && sq_en) begin
            rad = {16'h0, sq_rad} << FB;
            repeat (TS + 1) @(posedge clk);
            #1; sq_root = isqrt(rad); sq_valid = 1'b1;
            @(posedge clk);
            #1; sq_valid = 1'b0;
         end
      end
   endtask

   task automatic dv_engine();
      logic [31:0] x, y, qv;
      int idx;
      forever begin
         @(negedge clk);
         if (dv_start) begin
            x = {16'h0, dv_x}; y = {16'h0, dv_y};
            idx = dv_cnt; dv_cnt++;
            repeat (TD + 1) @(posedge clk);
            #1;
            dv_dbz = (y == 0);
            qv = (y == 0) ? 32'd0 : (x << FB) / y;
            dv_ovf = (qv > 32'h7FFF) || (idx == ovf_at);
            dv_q = qv[15:0]; dv_valid = 1'b1;
            @(posedge clk);
            #1; dv_valid = 1'b0; dv_dbz = 1'b0; dv_ovf = 1'b0;
         end
      end
   endtask

   task automatic run_vec(input logic [W-1:0] a, b, c, d, output int n);
      check("in_ready_before", in_ready, 1'b1);
      h0 = a; h1 = b; h2 = c; h3 = d; dv_cnt = 0;
      in_valid = 1'b1;
      @(posedge clk);
      #1; in_valid = 1'b0; n = 0;
      while (!out_valid && n < 2000) begin
         @(posedge clk);
         #1; n++;
      end
      check("done_within_bound", n < 2000, 1'b1);
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clk);
      #1; out_ready = 1'b0;
      check("out_valid_cleared", out_valid, 1'b0);
      check("in_ready_back", in_ready, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      h0 = '0; h1 = '0; h2 = '0; h3 = '0;
      sq_valid = 1'b0; sq_root = '0; dv_valid = 1'b0; dv_q = '0; dv_dbz = 1'b0; dv_ovf = 1'b0;
      fork
         sq_engine();
         dv_engine();
      join_none

      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_starts", {sq_start, dv_start}, 2'b00);
      check("rst_q", {q0, q1, q2, q3}, 0);
      check("rst_norm", norm, 0);
      check("rst_sq_rad", sq_rad, 0);
      check("rst_dv_xy", {dv_x, dv_y}, 0);
      reset = 1'b0;

      // Unit vector along h0
      run_vec(16'h0100, 16'h0000, 16'h0000, 16'h0000, cyc);
      check("t1_latency", cyc, LAT);
      check("t1_norm", norm, 16'h0100);
      check("t1_q0", q0, 16'h0100);
      check("t1_q123", {q1, q2, q3}, 0);
      check("t1_err", err, 1'b0);
      release_out();

      // Mixed signs, then consumer stalls with stray engine pulses
      run_vec(16'h0300, 16'hFC00, 16'h0000, 16'h0000, cyc);
      check("t2_latency", cyc, LAT);
      check("t2_sq_rad", sq_rad, 16'h1900);
      check("t2_norm", norm, 16'h0500);
      check("t2_q0", q0, 16'h0099);
      check("t2_q1", q1, 16'hFF34);
      check("t2_q23", {q2, q3}, 0);
      check("t2_err", err, 1'b0);
      for (int k = 0; k < 10; k++) begin
         if (k == 3) begin sq_root = 16'h0777; sq_valid = 1'b1; end
         if (k == 6) begin dv_q = 16'h1234; dv_valid = 1'b1; end
         @(posedge clk);
         #1; sq_valid = 1'b0; dv_valid = 1'b0;
         check("hold_out_valid", out_valid, 1'b1);
         check("hold_in_ready", in_ready, 1'b0);
         check("hold_q0_q1", {q0, q1}, {16'h0099, 16'hFF34});
         check("hold_norm_err", {norm, err}, {16'h0500, 1'b0});
      end
      release_out();

      // All-zero vector: no divisions, error flagged
      run_vec(16'h0000, 16'h0000, 16'h0000, 16'h0000, cyc);
      check("t3_latency", cyc, 3 + TS);
      check("t3_no_dv_start", dv_cnt, 0);
      check("t3_norm", norm, 0);
      check("t3_q", {q0, q1, q2, q3}, 0);
      check("t3_err", err, 1'b1);
      release_out();

      // Saturating squares, forced divider overflow on element 1
      ovf_at = 1;
      run_vec(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, cyc);
      ovf_at = -1;
      check("t4_sq_rad", sq_rad, MAX_U);
      check("t4_norm", norm, 16'h0FFF);
      check("t4_q0", q0, 16'h0800);
      check("t4_q1", q1, MAX_POS);
      check("t4_q23", {q2, q3}, {16'h0800, 16'h0800});
      check("t4_err", err, 1'b1);
      release_out();

      // Reset while waiting on the divider; its late pulse must be ignored
      check("t5_in_ready", in_ready, 1'b1);
      h0 = 16'h0100; h1 = '0; h2 = '0; h3 = '0; dv_cnt = 0;
      in_valid = 1'b1;
      @(posedge clk);
      #1; in_valid = 1'b0; cyc = 0;
      while (!dv_start && cyc < 200) begin
         @(posedge clk);
         #1; cyc++;
      end
      check("t5_dv_start_seen", dv_start, 1'b1);
      @(posedge clk);
      #1; reset = 1'b1;
      @(posedge clk);
      #1; reset = 1'b0;
      check("t5_rst_in_ready", in_ready, 1'b1);
      check("t5_rst_out_valid", out_valid, 1'b0);
      check("t5_rst_norm_q0", {norm, q0}, 0);
      check("t5_rst_err_dvx", {err, dv_x}, 0);
      repeat (TD + 6) @(posedge clk);
      #1; sq_root = 16'h0100; sq_valid = 1'b1;
      @(posedge clk);
      #1; sq_valid = 1'b0;
      @(posedge clk);
      #1;
      check("t5_stray_in_ready", in_ready, 1'b1);
      check("t5_stray_out_valid", out_valid, 1'b0);
      check("t5_stray_norm_q0", {norm, q0}, 0);

      // Most negative input: clamped square and clamped magnitude
      run_vec(16'h8000, 16'h0000, 16'h0000, 16'h0000, cyc);
      check("t6_latency", cyc, LAT);
      check("t6_sq_rad", sq_rad, MAX_U);
      check("t6_norm", norm, 16'h0FFF);
      check("t6_q0", q0, 16'hF800);
      check("t6_err", err, 1'b0);
      release_out();

`ifdef NORM_SEQ_TIMEOUT_EN
      sq_en = 1'b0;
      run_vec(16'h0100, 16'h0000, 16'h0000, 16'h0000, cyc);
      sq_en = 1'b1;
      check("tmo_latency", cyc, 2 + TMO);
      check("tmo_err", err, 1'b1);
      check("tmo_q", {q0, q1, q2, q3}, 0);
      release_out();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
